// File: rtl/if_fetch_ctrl_pkg.sv
// Shared constants for the instruction-fetch controller: reset vector,
// fetch state encodings and the next-PC source tags.
package if_fetch_ctrl_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
   localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;

   localparam logic [1:0] FS_REQ  = 2'd0;
   localparam logic [1:0] FS_WAIT = 2'd1;
   localparam logic [1:0] FS_HOLD = 2'd2;

   typedef enum logic [1:0] {
      SRC_SEQ  = 2'd0,
      SRC_PEND = 2'd1,
      SRC_BP   = 2'd2
   } adv_src_e;

   function automatic logic pc_misaligned(input logic [31:0] pc);
      return pc[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/if_fetch_ctrl_next_pc_sel.sv
// Next-PC priority mux: redirect target (exception over EX mispredict) and
// the address to fetch after the current instruction is consumed.
module if_fetch_ctrl_next_pc_sel
   import if_fetch_ctrl_pkg::*;
(
   input  logic        exc_valid,
   input  logic [31:0] exc_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        bp_taken,
   input  logic [31:0] bp_target,
   input  logic        pend_tgt_v,
   input  logic [31:0] pend_tgt,
   input  logic [31:0] fetch_pc,
   output logic        redir_event,
   output logic [31:0] redir_pc,
   output logic [31:0] adv_pc
);

   adv_src_e adv_src;

   always_comb begin
      redir_event = exc_valid | redirect_valid;
      redir_pc    = exc_valid ? exc_pc : redirect_pc;
   end

   // A prediction arriving in the very cycle its delay slot is consumed is used directly.
   always_comb begin
      if (bp_taken) begin
         adv_src = SRC_BP;
      end else if (pend_tgt_v) begin
         adv_src = SRC_PEND;
      end else begin
         adv_src = SRC_SEQ;
      end
      case (adv_src)
         SRC_BP:   adv_pc = bp_target;
         SRC_PEND: adv_pc = pend_tgt;
         default:  adv_pc = fetch_pc + 32'd4;
      endcase
   end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, runs a single-outstanding
// instruction-memory handshake and presents {pc, inst} to the IF/ID register.
module if_fetch_ctrl
   import if_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        exc_valid,
   input  logic [31:0] exc_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        bp_taken,
   input  logic [31:0] bp_target,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic [31:0] inst_rdata,
   input  logic        inst_data_ok,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_adel
);

   logic [1:0]  state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic [31:0] pend_tgt_q, pend_tgt_d;
   logic        pend_tgt_v_q, pend_tgt_v_d;
   logic        discard_q, discard_d;
   logic        if_valid_q, if_valid_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_inst_q, if_inst_d;
   logic        if_adel_q, if_adel_d;

   logic        redir_event;
   logic [31:0] redir_pc;
   logic [31:0] adv_pc;
   logic        fetch_misaligned;
   logic        consume;

   if_fetch_ctrl_next_pc_sel u_next_pc_sel (
      .exc_valid      (exc_valid),
      .exc_pc         (exc_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .bp_taken       (bp_taken),
      .bp_target      (bp_target),
      .pend_tgt_v     (pend_tgt_v_q),
      .pend_tgt       (pend_tgt_q),
      .fetch_pc       (fetch_pc_q),
      .redir_event    (redir_event),
      .redir_pc       (redir_pc),
      .adv_pc         (adv_pc)
   );

   assign fetch_misaligned = pc_misaligned(fetch_pc_q);
   assign inst_req         = !rst && (state_q == FS_REQ) && !fetch_misaligned;
   assign inst_addr        = fetch_pc_q;
   assign consume          = if_valid_q && !stall;

   assign if_valid = if_valid_q;
   assign if_pc    = if_pc_q;
   assign if_inst  = if_inst_q;
   assign if_adel  = if_adel_q;

   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      req_pc_d     = req_pc_q;
      pend_tgt_d   = pend_tgt_q;
      pend_tgt_v_d = pend_tgt_v_q;
      discard_d    = discard_q;
      if_valid_d   = if_valid_q;
      if_pc_d      = if_pc_q;
      if_inst_d    = if_inst_q;
      if_adel_d    = if_adel_q;

      // The predicted branch's delay slot is whatever is in flight or held now.
      if (bp_taken) begin
         pend_tgt_d   = bp_target;
         pend_tgt_v_d = 1'b1;
      end

      case (state_q)
         FS_REQ: begin
            if (fetch_misaligned) begin
               if_valid_d = 1'b1;
               if_adel_d  = 1'b1;
               if_inst_d  = ZERO_WORD;
               if_pc_d    = fetch_pc_q;
               state_d    = FS_HOLD;
            end else if (inst_addr_ok) begin
               req_pc_d = fetch_pc_q;
               state_d  = FS_WAIT;
            end
         end
         FS_WAIT: begin
            if (inst_data_ok) begin
               if (discard_q) begin
                  discard_d = 1'b0;
                  state_d   = FS_REQ;
               end else begin
                  if_valid_d = 1'b1;
                  if_adel_d  = 1'b0;
                  if_pc_d    = req_pc_q;
                  if_inst_d  = inst_rdata;
                  state_d    = FS_HOLD;
               end
            end
         end
         FS_HOLD: begin
            if (consume) begin
               if_valid_d   = 1'b0;
               fetch_pc_d   = adv_pc;
               pend_tgt_v_d = 1'b0;
               state_d      = FS_REQ;
            end
         end
         default: state_d = FS_REQ;
      endcase

      // Redirects override everything above, including a stalled held instruction.
      if (redir_event) begin
         fetch_pc_d   = redir_pc;
         pend_tgt_v_d = 1'b0;
         if_valid_d   = 1'b0;
         if_adel_d    = 1'b0;
         if ((state_q == FS_WAIT) && !inst_data_ok) begin
            discard_d = 1'b1;
            state_d   = FS_WAIT;
         end else if (inst_req && inst_addr_ok) begin
            discard_d = 1'b1;
            state_d   = FS_WAIT;
         end else begin
            discard_d = 1'b0;
            state_d   = FS_REQ;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= FS_REQ;
         fetch_pc_q   <= RESET_PC;
         req_pc_q     <= ZERO_WORD;
         pend_tgt_q   <= ZERO_WORD;
         pend_tgt_v_q <= 1'b0;
         discard_q    <= 1'b0;
         if_valid_q   <= 1'b0;
         if_pc_q      <= ZERO_WORD;
         if_inst_q    <= ZERO_WORD;
         if_adel_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         req_pc_q     <= req_pc_d;
         pend_tgt_q   <= pend_tgt_d;
         pend_tgt_v_q <= pend_tgt_v_d;
         discard_q    <= discard_d;
         if_valid_q   <= if_valid_d;
         if_pc_q      <= if_pc_d;
         if_inst_q    <= if_inst_d;
         if_adel_q    <= if_adel_d;
      end
   end

endmodule
